// File: rtl/ifu_fetch_queue_pkg.sv
// Shared fetch-path widths, reset PC default and the buffered entry layout.
package ifu_fetch_queue_pkg;

  localparam int unsigned InstAddrBus = 64;
  localparam int unsigned InstBus     = 32;

  localparam logic [InstAddrBus-1:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

  typedef logic [InstAddrBus-1:0] inst_addr_t;
  typedef logic [InstBus-1:0]     inst_t;

  typedef struct packed {
    inst_addr_t pc;
    inst_t      inst;
  } fq_entry_t;

  function automatic inst_addr_t align_pc(input inst_addr_t pc);
    return pc & ~inst_addr_t'(3);
  endfunction

endpackage

// File: rtl/ifu_sync_fifo.sv
// Power-of-two synchronous FIFO with flush; head data is read combinationally.
module ifu_sync_fifo #(
  parameter int unsigned WIDTH = 96,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head_data
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_eff, pop_eff;

  assign push_eff = push && !flush;
  assign pop_eff  = pop && !flush && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_eff) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_eff)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push_eff) - CW'(pop_eff);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push_eff) mem_q[wr_ptr_q] <= push_data;
  end

  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  a_count_bound: assert property (@(posedge clk) disable iff (!rst) count_q <= CW'(DEPTH));

endmodule

// File: rtl/ifu_fetch_queue.sv
// Fetch unit: issues in-order instruction requests, buffers {pc, inst} responses
// and hands them to the core; a redirect flushes the buffer and squashes in-flight responses.
module ifu_fetch_queue
  import ifu_fetch_queue_pkg::*;
#(
  parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [63:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_inst
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DepthLim = DEPTH[CW:0];

  typedef logic [CW-1:0] cnt_t;

  inst_addr_t fpc_q, fpc_d;
  inst_addr_t rpc_q, rpc_d;
  cnt_t       outstanding_q, outstanding_d;
  cnt_t       drop_q, drop_d;

  cnt_t       fifo_count;
  fq_entry_t  head;
  fq_entry_t  push_entry;
  logic [CW:0] inflight;
  logic       req_fire;
  logic       resp_keep;
  logic       fifo_pop;
  inst_addr_t redir_pc;

  assign redir_pc  = align_pc(redirect_pc);
  assign inflight  = {1'b0, fifo_count} + {1'b0, outstanding_q};

  assign mem_req_valid = rst && !redirect_valid && (inflight < DepthLim);
  assign mem_req_addr  = fpc_q;
  assign req_fire      = mem_req_valid && mem_req_ready;

  assign resp_keep  = mem_resp_valid && !redirect_valid && (drop_q == '0);
  assign push_entry = '{pc: rpc_q, inst: mem_resp_data};

  assign out_valid = rst && (fifo_count != '0);
  assign out_pc    = out_valid ? head.pc   : '0;
  assign out_inst  = out_valid ? head.inst : '0;
  assign fifo_pop  = out_valid && out_ready && !redirect_valid;

  always_comb begin
    fpc_d         = fpc_q;
    rpc_d         = rpc_q;
    outstanding_d = outstanding_q + cnt_t'(req_fire) - cnt_t'(mem_resp_valid);
    drop_d        = drop_q;
    if (redirect_valid) begin
      fpc_d  = redir_pc;
      rpc_d  = redir_pc;
      // Everything still in flight after this cycle belongs to the old stream.
      drop_d = outstanding_d;
    end else begin
      if (req_fire)  fpc_d = fpc_q + 64'd4;
      if (resp_keep) rpc_d = rpc_q + 64'd4;
      if (mem_resp_valid && (drop_q != '0)) drop_d = drop_q - cnt_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fpc_q         <= RESET_PC;
      rpc_q         <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      fpc_q         <= fpc_d;
      rpc_q         <= rpc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  ifu_sync_fifo #(
    .WIDTH ($bits(fq_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (resp_keep),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .count     (fifo_count),
    .head_data (head)
  );

  a_resp_expected: assert property (@(posedge clk) disable iff (!rst)
    mem_resp_valid |-> (outstanding_q != '0));

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Directed bench for ifu_fetch_queue with a 1-cycle in-order instruction memory model.
module tb_ifu_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_inst;

  int n_checks = 0;
  int n_errors = 0;
  int n_fire   = 0;
  logic        resp_en;
  logic [63:0] pend_q[$];

  always #5 clk = ~clk;

  ifu_fetch_queue #(
    .RESET_PC (64'h0000_0000_8000_0000),
    .DEPTH    (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory answers the oldest accepted request each cycle resp_en is high.
  task automatic drive_resp();
    logic [63:0] a;
    if (rst && resp_en && pend_q.size() != 0) begin
      a = pend_q[0];
      mem_resp_valid = 1'b1;
      mem_resp_data  = a[31:0] ^ 32'hDEAD_0000;
    end else begin
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
    end
  endtask

  task automatic tick();
    logic fire, resp, in_rst;
    logic [63:0] a;
    @(negedge clk);
    fire   = mem_req_valid && mem_req_ready;
    a      = mem_req_addr;
    resp   = mem_resp_valid;
    in_rst = !rst;
    @(posedge clk);
    #1;
    if (in_rst) begin
      pend_q.delete();
    end else begin
      if (resp) void'(pend_q.pop_front());
      if (fire) begin
        pend_q.push_back(a);
        n_fire++;
      end
    end
    drive_resp();
  endtask

  task automatic do_reset();
    rst            = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    mem_req_ready  = 1'b0;
    out_ready      = 1'b0;
    resp_en        = 1'b0;
    drive_resp();
    tick();
    tick();
    rst = 1'b1;
    #1;
  endtask

  initial begin
    rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    mem_req_ready = 1'b0; out_ready = 1'b0; resp_en = 1'b0;
    mem_resp_valid = 1'b0; mem_resp_data = '0;

    // Reset state
    tick();
    tick();
    check("rst_req_valid", mem_req_valid, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_pc", out_pc, 0);
    check("rst_out_inst", out_inst, 0);

    // Steady stream
    do_reset();
    mem_req_ready = 1'b1; out_ready = 1'b1; resp_en = 1'b1;
    #1;
    check("s_req_valid0", mem_req_valid, 1);
    check("s_req_addr0", mem_req_addr, 64'h8000_0000);
    tick();
    check("s_ov_c1", out_valid, 0);
    check("s_req_addr1", mem_req_addr, 64'h8000_0004);
    tick();
    for (int i = 0; i < 6; i++) begin
      check("s_ov", out_valid, 1);
      check("s_pc", out_pc, 64'h8000_0000 + 64'(4 * i));
      check("s_inst", out_inst, 32'h5EAD_0000 + 32'(4 * i));
      tick();
    end

    // Output back-pressure: issue capped at DEPTH
    do_reset();
    n_fire = 0;
    mem_req_ready = 1'b1; resp_en = 1'b1; out_ready = 1'b0;
    repeat (8) tick();
    check("bp_fires", n_fire, 4);
    check("bp_req_valid", mem_req_valid, 0);
    check("bp_head", out_pc, 64'h8000_0000);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_req_valid_pop", mem_req_valid, 1);
    check("bp_addr_pop", mem_req_addr, 64'h8000_0010);
    check("bp_head_pop", out_pc, 64'h8000_0004);
    tick();
    tick();
    check("bp_fires2", n_fire, 5);
    check("bp_req_valid2", mem_req_valid, 0);

    // Memory not ready: request held stable
    do_reset();
    mem_req_ready = 1'b0; resp_en = 1'b1; out_ready = 1'b1;
    repeat (5) begin
      check("nr_valid", mem_req_valid, 1);
      check("nr_addr", mem_req_addr, 64'h8000_0000);
      tick();
    end
    mem_req_ready = 1'b1;
    check("nr_addr_last", mem_req_addr, 64'h8000_0000);
    tick();
    check("nr_addr_adv", mem_req_addr, 64'h8000_0004);

    // Redirect with 2 outstanding and 1 buffered
    do_reset();
    mem_req_ready = 1'b1; out_ready = 1'b0; resp_en = 1'b0;
    repeat (3) tick();
    mem_req_ready = 1'b0; resp_en = 1'b1;
    drive_resp();
    tick();
    resp_en = 1'b0;
    drive_resp();
    check("rd_pre_ov", out_valid, 1);
    check("rd_pre_pc", out_pc, 64'h8000_0000);
    redirect_valid = 1'b1; redirect_pc = 64'h8000_1002; mem_req_ready = 1'b1;
    #1;
    check("rd_req_blocked", mem_req_valid, 0);
    tick();
    redirect_valid = 1'b0; resp_en = 1'b1;
    drive_resp();
    #1;
    check("rd_flushed", out_valid, 0);
    check("rd_req_valid", mem_req_valid, 1);
    check("rd_addr", mem_req_addr, 64'h8000_1000);
    tick();
    check("rd_drop1", out_valid, 0);
    tick();
    check("rd_drop2", out_valid, 0);
    tick();
    check("rd_ov", out_valid, 1);
    check("rd_pc", out_pc, 64'h8000_1000);
    check("rd_inst", out_inst, 32'h5EAD_1000);

    // Redirect coinciding with a response and a pop
    do_reset();
    mem_req_ready = 1'b1; out_ready = 1'b0; resp_en = 1'b0;
    repeat (3) tick();
    mem_req_ready = 1'b0; resp_en = 1'b1;
    drive_resp();
    tick();
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h8000_2000;
    tick();
    redirect_valid = 1'b0; mem_req_ready = 1'b1;
    #1;
    check("rc_ov", out_valid, 0);
    check("rc_pc0", out_pc, 0);
    check("rc_inst0", out_inst, 0);
    check("rc_addr", mem_req_addr, 64'h8000_2000);
    tick();
    check("rc_drop", out_valid, 0);
    tick();
    check("rc_ov2", out_valid, 1);
    check("rc_pc", out_pc, 64'h8000_2000);
    check("rc_inst", out_inst, 32'h5EAD_2000);

    // Mid-stream reset
    do_reset();
    mem_req_ready = 1'b1; out_ready = 1'b1; resp_en = 1'b1;
    repeat (4) tick();
    check("mr_pre_ov", out_valid, 1);
    rst = 1'b0;
    drive_resp();
    #1;
    check("mr_ov", out_valid, 0);
    check("mr_req_valid", mem_req_valid, 0);
    tick();
    rst = 1'b1;
    #1;
    check("mr_req_valid_post", mem_req_valid, 1);
    check("mr_addr_post", mem_req_addr, 64'h8000_0000);
    check("mr_ov_post", out_valid, 0);
    check("mr_pc_post", out_pc, 0);
    tick();
    tick();
    check("mr_first_ov", out_valid, 1);
    check("mr_first_pc", out_pc, 64'h8000_0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
